// File: rtl/axi4_memory_read_arbiter_if.sv
// Bundles the requester-side and memory-side AXI4 read channel signals of
// axi4_memory_read_arbiter.
// The master modport is the arbiter's view: it drives the memory AR channel and
// the requester R channel. The slave modport is the surrounding logic's view:
// the cache miss handlers plus the AXI4 slave.
interface axi4_memory_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    // Requester side: 0 = instruction cache refill, 1 = data cache refill
    logic [1:0]              reqArValid;
    logic [1:0]              reqArReady;
    logic [2*ADDR_WIDTH-1:0] reqArAddr;
    logic [15:0]             reqArLen;
    logic [1:0]              reqRValid;
    logic [1:0]              reqRReady;
    logic [DATA_WIDTH-1:0]   reqRData;
    logic                    reqRLast;
    logic [1:0]              reqRResp;

    // Memory side: AXI4 read address channel
    logic                    mArValid;
    logic                    mArReady;
    logic [1:0]              mArId;
    logic [ADDR_WIDTH-1:0]   mArAddr;
    logic [7:0]              mArLen;
    logic [2:0]              mArSize;
    logic [1:0]              mArBurst;

    // Memory side: AXI4 read data channel
    logic                    mRValid;
    logic                    mRReady;
    logic [1:0]              mRId;
    logic [DATA_WIDTH-1:0]   mRData;
    logic [1:0]              mRResp;
    logic                    mRLast;

    // Sticky status
    logic                    errUnknownId;

    modport master (
        input  reqArValid, reqArAddr, reqArLen, reqRReady,
        input  mArReady, mRValid, mRId, mRData, mRResp, mRLast,
        output reqArReady, reqRValid, reqRData, reqRLast, reqRResp,
        output mArValid, mArId, mArAddr, mArLen, mArSize, mArBurst, mRReady,
        output errUnknownId
    );

    modport slave (
        output reqArValid, reqArAddr, reqArLen, reqRReady,
        output mArReady, mRValid, mRId, mRData, mRResp, mRLast,
        input  reqArReady, reqRValid, reqRData, reqRLast, reqRResp,
        input  mArValid, mArId, mArAddr, mArLen, mArSize, mArBurst, mRReady,
        input  errUnknownId
    );
endinterface

// File: rtl/axi4_memory_read_arbiter.sv
// axi4_memory_read_arbiter
// Shares one AXI4 read address/data channel between the instruction cache
// refill (requester 0) and the data cache refill (requester 1). AR requests
// are arbitrated and tagged with ARID = requester index. In-flight bursts are
// counted per requester. R beats are routed back by RID.
// Optional build macro RSD_AXI_READ_ARB_FIXED_PRIORITY_EN: when it is defined,
// requester 1 always wins a tie. Otherwise ties are broken round-robin.
module axi4_memory_read_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      negResetIn,
    axi4_memory_read_arbiter_if.master bus
);
    // The counter is one bit wider than needed for MAX_OUTSTANDING - 1, so it
    // can hold the full value MAX_OUTSTANDING.
    localparam int                    CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [2:0]            AR_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0]            BURST_INCR = 2'b01;

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_ISSUE = 1'b1;

    logic [0:0]       state;
    logic             grant;          // requester that owns the current AR issue
    logic [CNT_W-1:0] outstanding [2];
    logic [1:0]       eligible;
    logic             anyEligible;
    logic             grantNext;
    logic             arHandshake;
    logic             rHandshake;
    logic [1:0]       cntInc;
    logic [1:0]       cntDec;

`ifndef RSD_AXI_READ_ARB_FIXED_PRIORITY_EN
    logic             rrPtr;          // requester favoured on the next tie
`endif

    // A requester competes only while it has room for another burst
    always_comb begin
        eligible = 2'b00;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = bus.reqArValid[i] && (outstanding[i] < CNT_MAX);
        end
        anyEligible = |eligible;
    end

    // Pick the requester to grant if the FSM is idle this cycle
    always_comb begin
`ifdef RSD_AXI_READ_ARB_FIXED_PRIORITY_EN
        grantNext = eligible[1];
`else
        if (&eligible) begin
            grantNext = rrPtr;
        end else begin
            grantNext = eligible[1];
        end
`endif
    end

    // Handshake qualifiers and per-requester counter strobes
    always_comb begin
        arHandshake = (state == STATE_ISSUE) && bus.mArValid && bus.mArReady;
        rHandshake  = bus.mRValid && bus.mRReady;
        cntInc      = 2'b00;
        cntDec      = 2'b00;
        if (arHandshake) begin
            cntInc = grant ? 2'b10 : 2'b01;
        end
        // A beat with an unknown RID never completes a tracked burst
        if (rHandshake && bus.mRLast && !bus.mRId[1]) begin
            cntDec = bus.mRId[0] ? 2'b10 : 2'b01;
        end
    end

    // The accept pulse goes to the owner in the cycle the slave takes the address
    always_comb begin
        bus.reqArReady = 2'b00;
        if (arHandshake) begin
            bus.reqArReady[grant] = 1'b1;
        end
    end

    // AR issue FSM: latch the winner's request in IDLE, hold it in ISSUE until ARREADY
    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            state        <= STATE_IDLE;
            grant        <= 1'b0;
            bus.mArValid <= 1'b0;
            bus.mArId    <= 2'b00;
            bus.mArAddr  <= '0;
            bus.mArLen   <= 8'd0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (anyEligible) begin
                        grant        <= grantNext;
                        bus.mArValid <= 1'b1;
                        bus.mArId    <= {1'b0, grantNext};
                        bus.mArAddr  <= grantNext ? bus.reqArAddr[ADDR_WIDTH +: ADDR_WIDTH]
                                                  : bus.reqArAddr[0 +: ADDR_WIDTH];
                        bus.mArLen   <= grantNext ? bus.reqArLen[8 +: 8]
                                                  : bus.reqArLen[0 +: 8];
                        state        <= STATE_ISSUE;
                    end
                end
                STATE_ISSUE: begin
                    if (bus.mArReady) begin
                        bus.mArValid <= 1'b0;
                        state        <= STATE_IDLE;
                    end
                end
                default: begin
                    bus.mArValid <= 1'b0;
                    state        <= STATE_IDLE;
                end
            endcase
        end
    end

`ifndef RSD_AXI_READ_ARB_FIXED_PRIORITY_EN
    // After each issue, the other requester gets the next tie
    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            rrPtr <= 1'b0;
        end else if (arHandshake) begin
            rrPtr <= ~grant;
        end
    end
`endif

    // Outstanding-burst counters. A simultaneous issue and completion cancel out.
    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            for (int i = 0; i < 2; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cntInc[i] && !cntDec[i] && (outstanding[i] != CNT_MAX)) begin
                    outstanding[i] <= outstanding[i] + CNT_ONE;
                end else if (cntDec[i] && !cntInc[i] && (outstanding[i] != '0)) begin
                    outstanding[i] <= outstanding[i] - CNT_ONE;
                end
            end
        end
    end

    // Route R beats by RID; beats with an unknown RID are drained and seen by no requester
    always_comb begin
        bus.reqRValid = 2'b00;
        bus.mRReady   = 1'b0;
        if (bus.mRId[1]) begin
            bus.mRReady = 1'b1;
        end else begin
            bus.reqRValid[bus.mRId[0]] = bus.mRValid;
            bus.mRReady                = bus.reqRReady[bus.mRId[0]];
        end
    end

    // The R payload is shared by both requesters; valid alone selects the owner
    always_comb begin
        bus.reqRData = bus.mRData;
        bus.reqRLast = bus.mRLast;
        bus.reqRResp = bus.mRResp;
    end

    // Constant AR attributes: full-width beats, incrementing bursts
    always_comb begin
        bus.mArSize  = AR_SIZE;
        bus.mArBurst = BURST_INCR;
    end

    // Sticky error flag for any beat carrying an RID outside {0,1}
    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            bus.errUnknownId <= 1'b0;
        end else if (bus.mRValid && bus.mRId[1]) begin
            bus.errUnknownId <= 1'b1;
        end
    end

endmodule
